// File: rtl/any1_issue_scheduler.sv
// any1_issue_scheduler
//   Multi-lane ROB issue scheduler. Each cycle, every ROB entry that is ready
//   to execute is woken, and up to ISSUE_W woken entries are selected in age
//   order. When BRANCH_FIRST is set, ready branches are selected before older
//   non-branches. At most MEM_PORTS memory ops are selected per cycle.
//   Each selection is registered per lane and held under a valid/ready
//   handshake with the functional units. An in-flight mask stops an issued
//   entry from being selected again until the ROB reports it out.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   flush           synchronous pipeline flush (same effect as reset)
//   rob_que         ROB insert pointer; the entry at rob_que is the oldest
//   rob_*           per-entry ROB status vectors, ENTRIES bits each
//   wakeup_list     combinational vector of woken entries
//   issue_v         per-lane valid
//   issue_idx       per-lane ROB index; lane k is at bits [k*QW +: QW]
//   issue_rdy       per-lane functional-unit accept
module any1_issue_scheduler #(
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned QW           = 6,
    parameter int unsigned ISSUE_W      = 2,
    parameter int unsigned MEM_PORTS    = 1,
    parameter int unsigned BRANCH_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [QW-1:0]         rob_que,
    input  logic [ENTRIES-1:0]    rob_v,
    input  logic [ENTRIES-1:0]    rob_dec,
    input  logic [ENTRIES-1:0]    rob_cmt,
    input  logic [ENTRIES-1:0]    rob_out,
    input  logic [ENTRIES-1:0]    rob_argv,
    input  logic [ENTRIES-1:0]    rob_modok,
    input  logic [ENTRIES-1:0]    rob_mem,
    input  logic [ENTRIES-1:0]    rob_fc,
    input  logic [ENTRIES-1:0]    rob_branch,
    output logic [ENTRIES-1:0]    wakeup_list,
    output logic [ISSUE_W-1:0]    issue_v,
    output logic [ISSUE_W*QW-1:0] issue_idx,
    input  logic [ISSUE_W-1:0]    issue_rdy
);

    logic [ENTRIES-1:0] inflight;
    logic [ENTRIES-1:0] base_ok;
    logic [ENTRIES-1:0] fc_blk;
    logic [ENTRIES-1:0] mem_blk;
    logic [ENTRIES-1:0] picked;
    logic [ENTRIES-1:0] load_mask;
    logic [ISSUE_W-1:0] lane_v;
    logic [ISSUE_W-1:0] lane_free;
    logic [ISSUE_W-1:0] load;
    logic [QW-1:0]      lane_idx [ISSUE_W];
    logic [QW-1:0]      pick_idx [ISSUE_W];
    int unsigned        que_mod;
    int unsigned        rk [ENTRIES];

    assign que_mod   = 32'(rob_que) % ENTRIES;
    assign base_ok   = rob_v & rob_dec & rob_argv & rob_modok & ~rob_cmt & ~rob_out & ~inflight;
    assign fc_blk    = rob_v & rob_fc & ~rob_cmt;
    assign mem_blk   = rob_v & rob_mem & ~rob_cmt & ~rob_out;
    assign lane_free = ~lane_v | issue_rdy;
    assign issue_v   = lane_v;

    // Age rank; rank 0 is the entry at rob_que. The subtraction wraps modulo
    // ENTRIES, so ordering stays correct across the top-to-zero boundary.
    always_comb begin
        for (int unsigned n = 0; n < ENTRIES; n++) begin
            rk[n] = (n >= que_mod) ? (n - que_mod) : (n + ENTRIES - que_mod);
        end
    end

    always_comb begin
        wakeup_list = '0;
        for (int unsigned n = 0; n < ENTRIES; n++) begin
            logic ok;
            ok = base_ok[n];
            for (int unsigned m = 0; m < ENTRIES; m++) begin
                if (rk[m] < rk[n]) begin
                    if (fc_blk[m]) ok = 1'b0;
                    if (rob_mem[n] && mem_blk[m]) ok = 1'b0;
                end
            end
            wakeup_list[n] = ok;
        end
    end

    // Lanes are filled in ascending order. Each free lane takes the oldest
    // eligible branch (when branches go first), or else the oldest eligible
    // entry. The picked mask and the memory-op count carry over from lane to
    // lane, so no entry is picked twice and the MEM_PORTS limit holds.
    always_comb begin
        logic        found;
        int unsigned best_r;
        int unsigned best_n;
        int unsigned memcnt;
        picked = '0;
        load   = '0;
        memcnt = 0;
        found  = 1'b0;
        best_r = ENTRIES;
        best_n = 0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            pick_idx[k] = '0;
        end
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            found  = 1'b0;
            best_r = ENTRIES;
            best_n = 0;
            if (lane_free[k]) begin
                if (BRANCH_FIRST != 0) begin
                    for (int unsigned n = 0; n < ENTRIES; n++) begin
                        if (wakeup_list[n] && !picked[n] && rob_branch[n] &&
                            !(rob_mem[n] && memcnt >= MEM_PORTS) && rk[n] < best_r) begin
                            found  = 1'b1;
                            best_r = rk[n];
                            best_n = n;
                        end
                    end
                end
                if (!found) begin
                    for (int unsigned n = 0; n < ENTRIES; n++) begin
                        if (wakeup_list[n] && !picked[n] &&
                            !(rob_mem[n] && memcnt >= MEM_PORTS) && rk[n] < best_r) begin
                            found  = 1'b1;
                            best_r = rk[n];
                            best_n = n;
                        end
                    end
                end
                if (found) begin
                    load[k]     = 1'b1;
                    pick_idx[k] = QW'(best_n);
                    for (int unsigned n = 0; n < ENTRIES; n++) begin
                        if (n == best_n) begin
                            picked[n] = 1'b1;
                            if (rob_mem[n]) memcnt = memcnt + 1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        load_mask = '0;
        for (int unsigned n = 0; n < ENTRIES; n++) begin
            for (int unsigned k = 0; k < ISSUE_W; k++) begin
                if (load[k] && pick_idx[k] == QW'(n)) load_mask[n] = 1'b1;
            end
        end
    end

    always_comb begin
        issue_idx = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            issue_idx[k*QW +: QW] = lane_idx[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            lane_v   <= '0;
            inflight <= '0;
            for (int unsigned k = 0; k < ISSUE_W; k++) begin
                lane_idx[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < ISSUE_W; k++) begin
                if (lane_free[k]) begin
                    lane_v[k] <= load[k];
                    if (load[k]) lane_idx[k] <= pick_idx[k];
                end
            end
            // A newly loaded index wins over that edge's clear conditions.
            inflight <= (inflight & ~(rob_out | ~rob_v)) | load_mask;
        end
    end

endmodule

// File: tb/tb_any1_issue_scheduler.sv
// tb_any1_issue_scheduler
//   Directed scoreboard bench. Two instances share all inputs: the default
//   configuration (branch priority on) and one with BRANCH_FIRST=0. Expected
//   lane contents are queued when stimulus is applied and compared after the
//   next rising edge.
module tb_any1_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [5:0]  rob_que;
    logic [15:0] rob_v, rob_dec, rob_cmt, rob_out, rob_argv, rob_modok;
    logic [15:0] rob_mem, rob_fc, rob_branch;
    logic [1:0]  issue_rdy;
    logic [15:0] wakeup_list, ob_wakeup;
    logic [1:0]  issue_v, ob_v;
    logic [11:0] issue_idx, ob_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] v;
        logic [5:0] i0;
        logic [5:0] i1;
        logic [1:0] ov;
        logic [5:0] o0;
        logic [5:0] o1;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    any1_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_que(rob_que),
        .rob_v(rob_v), .rob_dec(rob_dec), .rob_cmt(rob_cmt), .rob_out(rob_out),
        .rob_argv(rob_argv), .rob_modok(rob_modok), .rob_mem(rob_mem),
        .rob_fc(rob_fc), .rob_branch(rob_branch), .wakeup_list(wakeup_list),
        .issue_v(issue_v), .issue_idx(issue_idx), .issue_rdy(issue_rdy)
    );

    any1_issue_scheduler #(.BRANCH_FIRST(0)) dut_ob (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_que(rob_que),
        .rob_v(rob_v), .rob_dec(rob_dec), .rob_cmt(rob_cmt), .rob_out(rob_out),
        .rob_argv(rob_argv), .rob_modok(rob_modok), .rob_mem(rob_mem),
        .rob_fc(rob_fc), .rob_branch(rob_branch), .wakeup_list(ob_wakeup),
        .issue_v(ob_v), .issue_idx(ob_idx), .issue_rdy(issue_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue the same expectation for both instances.
    task automatic push(input logic [1:0] v, input int a, input int b);
        exp_t e;
        e.v = v; e.i0 = 6'(a); e.i1 = 6'(b);
        e.ov = v; e.o0 = 6'(a); e.o1 = 6'(b);
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_v"}, 32'(issue_v), 32'(e.v));
            if (e.v[0]) chk({tag, "_l0"}, 32'(issue_idx[5:0]), 32'(e.i0));
            if (e.v[1]) chk({tag, "_l1"}, 32'(issue_idx[11:6]), 32'(e.i1));
            chk({tag, "_ob_v"}, 32'(ob_v), 32'(e.ov));
            if (e.ov[0]) chk({tag, "_ob_l0"}, 32'(ob_idx[5:0]), 32'(e.o0));
            if (e.ov[1]) chk({tag, "_ob_l1"}, 32'(ob_idx[11:6]), 32'(e.o1));
        end
    endtask

    task automatic rob_clear();
        rob_v = '0; rob_dec = '0; rob_cmt = '0; rob_out = '0; rob_argv = '0;
        rob_modok = '0; rob_mem = '0; rob_fc = '0; rob_branch = '0;
    endtask

    // Make entry n valid, decoded and ready to execute.
    task automatic mk(input int n, input bit mem, input bit fc, input bit br);
        logic [15:0] m;
        m = 16'd1 << n;
        rob_v |= m; rob_dec |= m; rob_argv |= m; rob_modok |= m;
        if (mem) rob_mem |= m;
        if (fc)  rob_fc |= m;
        if (br)  rob_branch |= m;
    endtask

    task automatic do_flush(input string tag);
        rob_clear();
        flush = 1'b1;
        push(2'b00, 0, 0);
        tick(tag);
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; rob_que = '0; issue_rdy = 2'b11;
        rob_clear();

        // Reset state
        push(2'b00, 0, 0); tick("rst0");
        push(2'b00, 0, 0); tick("rst1");
        chk("rst_idx", 32'(issue_idx), 32'd0);
        chk("rst_wake", 32'(wakeup_list), 32'd0);
        rst_n = 1'b1;
        push(2'b00, 0, 0); tick("idle");

        // Age order across the wrap boundary
        rob_que = 6'd14;
        mk(14, 0, 0, 0); mk(15, 0, 0, 0); mk(0, 0, 0, 0);
        #1 chk("wrap_wake", 32'(wakeup_list), 32'h0000C001);
        push(2'b11, 14, 15); tick("wrap_a");
        push(2'b01, 0, 0);   tick("wrap_b");
        push(2'b00, 0, 0);   tick("wrap_c");
        chk("wrap_wake_inflight", 32'(wakeup_list), 32'd0);
        rob_out = 16'h0001;
        push(2'b00, 0, 0);   tick("wrap_out");
        rob_out = 16'h0000;
        #1 chk("wrap_wake_again", 32'(wakeup_list), 32'h00000001);
        push(2'b01, 0, 0);   tick("wrap_reissue");

        // Branch priority versus oldest-first
        do_flush("fl2");
        rob_que = 6'd3;
        mk(3, 0, 0, 0); mk(5, 0, 1, 1);
        #1 chk("br_wake", 32'(wakeup_list), 32'h00000028);
        begin
            exp_t e;
            e.v = 2'b11;  e.i0 = 6'd5; e.i1 = 6'd3;
            e.ov = 2'b11; e.o0 = 6'd3; e.o1 = 6'd5;
            sb.push_back(e);
        end
        tick("br");

        // Memory ordering: younger mem waits for the older one to be out
        do_flush("fl3");
        rob_que = 6'd0;
        mk(2, 1, 0, 0); mk(3, 0, 0, 0); mk(4, 1, 0, 0);
        #1 chk("mem_wake", 32'(wakeup_list), 32'h0000000C);
        push(2'b11, 2, 3); tick("mem_a");
        push(2'b00, 0, 0); tick("mem_blocked");
        chk("mem_wake_blocked", 32'(wakeup_list), 32'd0);
        rob_out = 16'h0004;
        #1 chk("mem_wake_4", 32'(wakeup_list), 32'h00000010);
        push(2'b01, 4, 0); tick("mem_b");

        // Older uncommitted flow-control op blocks younger entries
        do_flush("fl4");
        rob_v = 16'h0002; rob_dec = 16'h0002; rob_modok = 16'h0002; rob_fc = 16'h0002;
        for (int i = 2; i <= 6; i++) mk(i, 0, 0, 0);
        #1 chk("fc_wake_blocked", 32'(wakeup_list), 32'd0);
        push(2'b00, 0, 0); tick("fc_none");
        rob_cmt = 16'h0002;
        #1 chk("fc_wake", 32'(wakeup_list), 32'h0000007C);
        push(2'b11, 2, 3); tick("fc_issue");

        // Lane 0 stalls, lane 1 keeps issuing
        do_flush("fl5");
        for (int i = 7; i <= 10; i++) mk(i, 0, 0, 0);
        issue_rdy = 2'b10;
        push(2'b11, 7, 8);  tick("hold_a");
        chk("hold_wake", 32'(wakeup_list), 32'h00000600);
        push(2'b11, 7, 9);  tick("hold_b");
        push(2'b11, 7, 10); tick("hold_c");
        push(2'b01, 7, 0);  tick("hold_d");
        chk("hold_inflight7", 32'(wakeup_list[7]), 32'd0);
        issue_rdy = 2'b11;
        push(2'b00, 0, 0);  tick("hold_release");

        // Flush and reset while both lanes hold selections
        do_flush("fl6");
        mk(1, 0, 0, 0); mk(2, 0, 0, 0);
        issue_rdy = 2'b00;
        push(2'b11, 1, 2); tick("fr_load");
        push(2'b11, 1, 2); tick("fr_hold");
        flush = 1'b1;
        push(2'b00, 0, 0); tick("fr_flush");
        chk("fr_flush_idx", 32'(issue_idx), 32'd0);
        flush = 1'b0;
        #1 chk("fr_wake", 32'(wakeup_list), 32'h00000006);
        push(2'b11, 1, 2); tick("fr_reissue");
        rst_n = 1'b0;
        push(2'b00, 0, 0); tick("fr_rst");
        rst_n = 1'b1;
        push(2'b11, 1, 2); tick("fr_reissue2");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
